// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment display drivers.
//   - SEG_A..SEG_G : bit position of each segment in a {g,f,e,d,c,b,a} word
//   - SEG_0..SEG_9 : lit-segment patterns for BCD digits (1 = segment on)
//   - SEG_BLANK    : all segments off
//   - idx_width()  : width of a counter/select that must hold 0..n-1
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] BIT_A = 7'b1 << SEG_A;
    localparam logic [6:0] BIT_B = 7'b1 << SEG_B;
    localparam logic [6:0] BIT_C = 7'b1 << SEG_C;
    localparam logic [6:0] BIT_D = 7'b1 << SEG_D;
    localparam logic [6:0] BIT_E = 7'b1 << SEG_E;
    localparam logic [6:0] BIT_F = 7'b1 << SEG_F;
    localparam logic [6:0] BIT_G = 7'b1 << SEG_G;

    localparam logic [6:0] SEG_0     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F;
    localparam logic [6:0] SEG_1     = BIT_B | BIT_C;
    localparam logic [6:0] SEG_2     = BIT_A | BIT_B | BIT_D | BIT_E | BIT_G;
    localparam logic [6:0] SEG_3     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_G;
    localparam logic [6:0] SEG_4     = BIT_B | BIT_C | BIT_F | BIT_G;
    localparam logic [6:0] SEG_5     = BIT_A | BIT_C | BIT_D | BIT_F | BIT_G;
    localparam logic [6:0] SEG_6     = BIT_A | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
    localparam logic [6:0] SEG_7     = BIT_A | BIT_B | BIT_C;
    localparam logic [6:0] SEG_8     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
    localparam logic [6:0] SEG_9     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_F | BIT_G;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// ---------------------------------------------------------------------------
// bcd_seg_decode
// Combinational BCD to 7-segment map. Codes 10..15 decode to blank; they are
// treated as "show nothing", not as errors.
//   bcd_i [3:0] : BCD digit
//   seg_o [6:0] : {g,f,e,d,c,b,a}, 1 = segment lit
// ---------------------------------------------------------------------------
module bcd_seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an N-digit 7-segment display. NUM/DP are
// captured into a shadow register on LOAD; one digit at a time is enabled for
// CLK_DIV cycles, the first BLANK_CYC of which keep every digit dark to avoid
// ghosting. All outputs are registered (one cycle behind the scan state).
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, a zero digit whose more-significant digits are all zero is
//   blanked (digit 0 always shows). AN and DP_OUT are unaffected.
//
// Ports
//   CLK    : system clock, rising edge
//   RST_N  : asynchronous active-low reset
//   NUM    : BCD digits, NUM[3:0] = digit 0 (rightmost)
//   DP     : decimal point per digit, 1 = lit
//   LOAD   : capture NUM/DP into the shadow register at this edge
//   SEG    : {g,f,e,d,c,b,a}, 1 = lit
//   DP_OUT : decimal point of the enabled digit
//   AN     : one-hot digit enable, 1 = digit on
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*N_DIGITS-1:0] NUM,
    input  logic [N_DIGITS-1:0]   DP,
    input  logic                  LOAD,
    output logic [6:0]            SEG,
    output logic                  DP_OUT,
    output logic [N_DIGITS-1:0]   AN
);

    localparam int IDX_W = idx_width(N_DIGITS);
    localparam int CNT_W = idx_width(CLK_DIV);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] num_q, num_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_out_q, dp_out_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic                  wrap;
    logic [3:0]            digit_sel;
    logic                  dp_sel;
    logic [6:0]            dec_seg;
    logic                  lz_blank;

    assign wrap = (cnt_q == CNT_W'(CLK_DIV - 1));

    // Prescaler, digit index and shadow register.
    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        num_d = LOAD ? NUM : num_q;
        dp_d  = LOAD ? DP  : dp_q;
    end

    // Mux the currently indexed digit out of the shadow register.
    always_comb begin
        digit_sel = 4'd0;
        dp_sel    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_sel = num_q[i*4 +: 4];
                dp_sel    = dp_q[i];
            end
        end
    end

    bcd_seg_decode u_dec (
        .bcd_i (digit_sel),
        .seg_o (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every more-significant digit are zero;
    // digit 0 is exempt so an all-zero value still reads "0".
    always_comb begin
        lz_blank = (idx_q != '0);
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(idx_q) && num_q[j*4 +: 4] != 4'd0) begin
                lz_blank = 1'b0;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Output register: dark during the blank interval after a digit switch.
    always_comb begin
        an_d     = '0;
        seg_d    = SEG_BLANK;
        dp_out_d = 1'b0;
        if (cnt_q >= CNT_W'(BLANK_CYC)) begin
            an_d     = N_DIGITS'(1) << idx_q;
            seg_d    = lz_blank ? SEG_BLANK : dec_seg;
            dp_out_d = dp_sel;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            num_q    <= '0;
            dp_q     <= '0;
            seg_q    <= SEG_BLANK;
            dp_out_q <= 1'b0;
            an_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            dp_q     <= dp_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            an_q     <= an_d;
        end
    end

    assign SEG    = seg_q;
    assign DP_OUT = dp_out_q;
    assign AN     = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int ND  = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [15:0]   NUM = '0;
    logic [3:0]    DP = '0;
    logic          LOAD = 1'b0;
    logic [6:0]    SEG;
    logic          DP_OUT;
    logic [3:0]    AN;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    seg7_scan_driver #(
        .N_DIGITS  (ND),
        .CLK_DIV   (DIV),
        .BLANK_CYC (BLK)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .NUM    (NUM),
        .DP     (DP),
        .LOAD   (LOAD),
        .SEG    (SEG),
        .DP_OUT (DP_OUT),
        .AN     (AN)
    );

    always #5 CLK = ~CLK;

    // Reference segment table.
    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // What digit position d of a displayed value must look like.
    function automatic logic [6:0] digit_look(input logic [15:0] val, input int d);
        int v;
        int upper;
        v     = (val >> (4 * d)) & 16'hF;
        upper = val >> (4 * d);
        if (LZ && d != 0 && upper == 0) return 7'h00;
        return ref_seg(v);
    endfunction

    // Behavioural model: cycles since reset release decide slot and phase.
    logic [15:0] m_num;
    logic [3:0]  m_dp;
    int          m_k;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpo;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_num <= '0;
            m_dp  <= '0;
            m_k   <= 0;
            e_an  <= '0;
            e_seg <= '0;
            e_dpo <= 1'b0;
        end else begin
            int phase;
            int d;
            phase = m_k % DIV;
            d     = (m_k / DIV) % ND;
            if (phase < BLK) begin
                e_an  <= '0;
                e_seg <= '0;
                e_dpo <= 1'b0;
            end else begin
                e_an  <= 4'(1 << d);
                e_seg <= digit_look(m_num, d);
                e_dpo <= m_dp[d];
            end
            if (LOAD) begin
                m_num <= NUM;
                m_dp  <= DP;
            end
            m_k <= m_k + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        n_chk++;
        if (AN !== e_an || SEG !== e_seg || DP_OUT !== e_dpo) begin
            n_fail++;
            $display("FAIL model t=%0t: AN=%b SEG=%h DP_OUT=%b, required AN=%b SEG=%h DP_OUT=%b",
                     $time, AN, SEG, DP_OUT, e_an, e_seg, e_dpo);
        end
        n_chk++;
        if ($countones(AN) > 1) begin
            n_fail++;
            $display("FAIL onehot t=%0t: AN=%b, required at most one bit set", $time, AN);
        end
    end

    task automatic chk(input string name, input logic [3:0] an, input logic [6:0] seg,
                       input logic dpo);
        n_chk++;
        if (AN !== an || SEG !== seg || DP_OUT !== dpo) begin
            n_fail++;
            $display("FAIL %s: AN=%b SEG=%h DP_OUT=%b, required AN=%b SEG=%h DP_OUT=%b",
                     name, AN, SEG, DP_OUT, an, seg, dpo);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic goto_edge(input int t);
        while (edge_n < t) tick();
    endtask

    initial begin
        // 1: reset held over three edges, then release.
        repeat (3) tick();
        chk("reset_hold", 4'b0000, 7'h00, 1'b0);
        RST_N = 1'b1;
        edge_n = 0;
        tick(); chk("rel_blank1", 4'b0000, 7'h00, 1'b0);
        tick(); chk("rel_blank2", 4'b0000, 7'h00, 1'b0);
        tick(); chk("rel_dig0",   4'b0001, 7'h3F, 1'b0);

        // 2: load 1234 with DP on digit 2.
        NUM = 16'h1234; DP = 4'b0100; LOAD = 1'b1;
        tick(); LOAD = 1'b0;
        goto_edge(5);  chk("s2_dig0", 4'b0001, 7'h66, 1'b0);
        goto_edge(12); chk("s2_dig1", 4'b0010, 7'h4F, 1'b0);
        goto_edge(20); chk("s2_dig2", 4'b0100, 7'h5B, 1'b1);
        goto_edge(28); chk("s2_dig3", 4'b1000, 7'h06, 1'b0);
        goto_edge(36); chk("s2_wrap", 4'b0001, 7'h66, 1'b0);

        // 3: NUM changes without LOAD, then LOAD on the wrap edge.
        NUM = 16'h9999;
        goto_edge(37); chk("s3_noload", 4'b0001, 7'h66, 1'b0);
        goto_edge(39); LOAD = 1'b1;
        tick(); LOAD = 1'b0;
        chk("s3_wrap_old", 4'b0001, 7'h66, 1'b0);
        goto_edge(41); chk("s3_blank", 4'b0000, 7'h00, 1'b0);
        goto_edge(43); chk("s3_new",   4'b0010, 7'h6F, 1'b0);

        // 4: non-BCD codes in the upper digits.
        goto_edge(44);
        NUM = 16'hFA00; DP = 4'b0000; LOAD = 1'b1;
        tick(); LOAD = 1'b0;
        goto_edge(46); chk("s4_dig1", 4'b0010, 7'h3F, 1'b0);
        goto_edge(52); chk("s4_dig2", 4'b0100, 7'h00, 1'b0);
        goto_edge(60); chk("s4_dig3", 4'b1000, 7'h00, 1'b0);
        goto_edge(68); chk("s4_dig0", 4'b0001, 7'h3F, 1'b0);

        // 5: asynchronous reset in the middle of digit 2's slot.
        goto_edge(84); chk("s5_pre", 4'b0100, 7'h00, 1'b0);
        #2 RST_N = 1'b0;
        #1 chk("s5_async", 4'b0000, 7'h00, 1'b0);
        tick(); tick();
        RST_N = 1'b1;
        edge_n = 0;
        tick(); chk("s5_blank1", 4'b0000, 7'h00, 1'b0);
        tick(); chk("s5_blank2", 4'b0000, 7'h00, 1'b0);
        tick(); chk("s5_dig0",   4'b0001, 7'h3F, 1'b0);

        // 6: leading zeros (blanked only when the option is built in).
        NUM = 16'h0050; DP = 4'b1000; LOAD = 1'b1;
        tick(); LOAD = 1'b0;
        goto_edge(5);  chk("s6_dig0", 4'b0001, 7'h3F, 1'b0);
        goto_edge(12); chk("s6_dig1", 4'b0010, 7'h6D, 1'b0);
        goto_edge(20); chk("s6_dig2", 4'b0100, LZ ? 7'h00 : 7'h3F, 1'b0);
        goto_edge(28); chk("s6_dig3", 4'b1000, LZ ? 7'h00 : 7'h3F, 1'b1);
        NUM = 16'h0000; DP = 4'b0000; LOAD = 1'b1;
        tick(); LOAD = 1'b0;
        goto_edge(36); chk("s6_zero0", 4'b0001, 7'h3F, 1'b0);
        goto_edge(44); chk("s6_zero1", 4'b0010, LZ ? 7'h00 : 7'h3F, 1'b0);
        goto_edge(48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
